jtag_tap_target: RTL and testbench
==================================

Name: jtag_tap_target

Overview:
- Target-side JTAG TAP: IEEE 1149.1 16-state controller, instruction register (IR), one-bit bypass register and a configurable-width test-vector data register (TVR).
- Sits directly downstream of the JTAG controller agent's pins and consumes the serial TMS/TDI stream the driver produces.
- Returns TDO and presents the captured test vector and the decoded instruction to the DUT-side logic.
- Instruction and vector widths match the global package enumerations.

Parameters:
- INSTR_WIDTH, 5, IR length; legal values 3/4/5 (JtagInstructionWidthEnum).
- DATA_WIDTH, 32, TVR length; legal values 8/16/24/32 (JtagTestVectorWidthEnum).
- IDCODE_VALUE, 32'h1000_0001, value loaded by IDCODE capture (optional feature only).

Ports:
- clk  input  1  JTAG test clock; all state updates on the rising edge.
- reset  input  1  asynchronous active-low reset.
- tms  input  1  test mode select.
- tdi  input  1  serial data in.
- tdo  output  1  serial data out.
- tdoEn  output  1  high while in Shift-DR or Shift-IR.
- tapState  output  4  current TAP state encoding.
- instrReg  output  INSTR_WIDTH  active instruction.
- instrValid  output  1  one-cycle pulse after Update-IR.
- dataIn  input  DATA_WIDTH  value captured into TVR at Capture-DR.
- dataOut  output  DATA_WIDTH  last TVR value committed at Update-DR.
- dataValid  output  1  one-cycle pulse after Update-DR when TVR is selected.

Behaviour:
- Reset (async assert, sync release) values:
  - tapState = TestLogicReset; instrReg = 0 (bypassRegister opcode).
  - shift registers = 0; dataOut = 0; tdo = 0; tdoEn = 0; instrValid = 0; dataValid = 0.
- FSM: standard 1149.1 transitions on sampled tms. States: TestLogicReset, RunTestIdle, SelectDR, CaptureDR, ShiftDR, Exit1DR, PauseDR, Exit2DR, UpdateDR, SelectIR, CaptureIR, ShiftIR, Exit1IR, PauseIR, Exit2IR, UpdateIR.
- Five consecutive tms=1 cycles reach TestLogicReset from any state.
- Entering TestLogicReset (via tms or reset) forces instrReg = 0.
- Instruction decode:
  - opcode 0 selects bypass.
  - opcode 1 selects TVR.
  - all other opcodes select bypass.
- CaptureIR: IR shift register loads the value with 2'b01 in its LSBs and zeros above.
- CaptureDR:
  - TVR selected: TVR shift register loads dataIn.
  - Bypass selected: bypass bit loads 0.
- ShiftIR/ShiftDR, each cycle in the state:
  - Active register shifts right; tdi enters the MSB.
  - tdo = active register LSB (combinational from the register). Outside shift states tdo = 0.
  - Shifting continues on the cycle tms=1 moves the FSM to Exit1.
- Pause states hold the shift contents.
- UpdateIR: instrReg <= IR shift register; instrValid pulses high the following cycle.
- UpdateDR: if TVR is selected, dataOut <= TVR shift register and dataValid pulses high. In bypass, no output change and no pulse.
- Bypass path: tdi-to-tdo latency is exactly one clk.
- Shift counts other than the register length are legal and shall not be flagged:
  - Short shift: partial shift is committed.
  - Long shift: leading bits fall off the LSB.
- Reset asserted mid-shift: immediate return to reset values; dataOut and instrReg are not updated.

Optional Feature:
- Macro: JTAG_TAP_IDCODE_EN.
- Defined:
  - Opcode 2 selects a 32-bit IDCODE register.
  - CaptureDR loads IDCODE_VALUE; shifting is identical to TVR.
  - UpdateDR does not change dataOut and raises no dataValid.
- Undefined: opcode 2 selects bypass and IDCODE_VALUE is unused.

Decomposition:
- Add to JtagGlobalPkg:
  - JtagTapStateEnum: 4-bit, TestLogicReset=4'hF, RunTestIdle=4'hC, SelectDR=4'h7, CaptureDR=4'h6, ShiftDR=4'h2, Exit1DR=4'h1, PauseDR=4'h3, Exit2DR=4'h0, UpdateDR=4'h5, SelectIR=4'h4, CaptureIR=4'hE, ShiftIR=4'hA, Exit1IR=4'h9, PauseIR=4'hB, Exit2IR=4'h8, UpdateIR=4'hD.
  - Opcode constants: bypass=0, testVector=1, idcode=2.
- Sub-module jtag_tap_fsm: next-state logic plus state register; outputs tapState.
- Top level holds IR, TVR, bypass and IDCODE registers and the tdo mux.

Test Plan:
- Reset then tms=1 for 5 cycles from RunTestIdle -> tapState=4'hF, instrReg=0, tdo=0, tdoEn=0.
- Load IR: shift 5'b00001 LSB-first -> tdo emits 1,0,0,0,0 (capture pattern). After UpdateIR: instrReg=1 and instrValid is a single pulse.
- TVR selected, dataIn=32'hDEAD_BEEF, shift in 32'hA5A5_1234 -> tdo emits DEAD_BEEF LSB-first. After UpdateDR: dataOut=32'hA5A5_1234 and dataValid pulses once.
- IR=0, shift tdi pattern 1,0,1,1 in ShiftDR -> tdo = 0,1,0,1 (one-clk delay). dataOut unchanged, no dataValid.
- Assert reset after 10 bits of a 32-bit TVR shift -> every output returns to its reset value immediately and dataOut keeps its prior value.
- JTAG_TAP_IDCODE_EN defined, IR=2, 32-bit shift -> tdo emits 32'h1000_0001 LSB-first. Macro undefined: IR=2 behaves as bypass.

Source files
------------

// File: rtl/jtag_tap_target_pkg.sv
// Shared types and constants for the target-side JTAG TAP: state encodings,
// opcodes and the data-register select decode.
package jtag_tap_target_pkg;

    localparam int unsigned TAP_STATE_WIDTH = 4;
    localparam int unsigned OPCODE_WIDTH    = 8;

    localparam int unsigned OP_BYPASS      = 0;
    localparam int unsigned OP_TEST_VECTOR = 1;
    localparam int unsigned OP_IDCODE      = 2;

    // IEEE 1149.1 state encodings as seen on tapState
    typedef enum logic [TAP_STATE_WIDTH-1:0] {
        ST_EXIT2_DR         = 4'h0,
        ST_EXIT1_DR         = 4'h1,
        ST_SHIFT_DR         = 4'h2,
        ST_PAUSE_DR         = 4'h3,
        ST_SELECT_IR        = 4'h4,
        ST_UPDATE_DR        = 4'h5,
        ST_CAPTURE_DR       = 4'h6,
        ST_SELECT_DR        = 4'h7,
        ST_EXIT2_IR         = 4'h8,
        ST_EXIT1_IR         = 4'h9,
        ST_SHIFT_IR         = 4'hA,
        ST_PAUSE_IR         = 4'hB,
        ST_RUN_TEST_IDLE    = 4'hC,
        ST_UPDATE_IR        = 4'hD,
        ST_CAPTURE_IR       = 4'hE,
        ST_TEST_LOGIC_RESET = 4'hF
    } jtag_tap_state_e;

    // Which data register sits between tdi and tdo
    typedef enum logic [1:0] {
        DR_SEL_BYPASS = 2'd0,
        DR_SEL_TVR    = 2'd1,
        DR_SEL_IDCODE = 2'd2
    } dr_sel_e;

    // Opcode to data-register decode; unknown opcodes fall back to bypass
    function automatic dr_sel_e decode_instr(input logic [OPCODE_WIDTH-1:0] opcode,
                                             input logic idcode_en);
        dr_sel_e sel;
        sel = DR_SEL_BYPASS;
        if (opcode == OPCODE_WIDTH'(OP_TEST_VECTOR)) begin
            sel = DR_SEL_TVR;
        end else if (idcode_en && (opcode == OPCODE_WIDTH'(OP_IDCODE))) begin
            sel = DR_SEL_IDCODE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register plus tms-driven next-state logic.
module jtag_tap_fsm
    import jtag_tap_target_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tms,
    output logic [TAP_STATE_WIDTH-1:0] tap_state,
    output logic [TAP_STATE_WIDTH-1:0] next_state_c
);

    jtag_tap_state_e state_q;
    jtag_tap_state_e state_d;

    // State register, reset parks the controller in Test-Logic-Reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Standard 1149.1 transition graph on sampled tms
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_TEST_LOGIC_RESET: state_d = tms ? ST_TEST_LOGIC_RESET : ST_RUN_TEST_IDLE;
            ST_RUN_TEST_IDLE:    state_d = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
            ST_SELECT_DR:        state_d = tms ? ST_SELECT_IR        : ST_CAPTURE_DR;
            ST_CAPTURE_DR:       state_d = tms ? ST_EXIT1_DR         : ST_SHIFT_DR;
            ST_SHIFT_DR:         state_d = tms ? ST_EXIT1_DR         : ST_SHIFT_DR;
            ST_EXIT1_DR:         state_d = tms ? ST_UPDATE_DR        : ST_PAUSE_DR;
            ST_PAUSE_DR:         state_d = tms ? ST_EXIT2_DR         : ST_PAUSE_DR;
            ST_EXIT2_DR:         state_d = tms ? ST_UPDATE_DR        : ST_SHIFT_DR;
            ST_UPDATE_DR:        state_d = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
            ST_SELECT_IR:        state_d = tms ? ST_TEST_LOGIC_RESET : ST_CAPTURE_IR;
            ST_CAPTURE_IR:       state_d = tms ? ST_EXIT1_IR         : ST_SHIFT_IR;
            ST_SHIFT_IR:         state_d = tms ? ST_EXIT1_IR         : ST_SHIFT_IR;
            ST_EXIT1_IR:         state_d = tms ? ST_UPDATE_IR        : ST_PAUSE_IR;
            ST_PAUSE_IR:         state_d = tms ? ST_EXIT2_IR         : ST_PAUSE_IR;
            ST_EXIT2_IR:         state_d = tms ? ST_UPDATE_IR        : ST_SHIFT_IR;
            ST_UPDATE_IR:        state_d = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
            default:             state_d = ST_TEST_LOGIC_RESET;
        endcase
    end

    assign tap_state    = state_q;
    assign next_state_c = state_d;

endmodule

// File: rtl/jtag_tap_target.sv
// Target-side JTAG TAP: controller, instruction register, bypass bit and a
// test-vector data register feeding DUT-side logic.
// Optional feature: define JTAG_TAP_IDCODE_EN to make opcode 2 select a 32-bit
// IDCODE register loaded with IDCODE_VALUE; otherwise opcode 2 is bypass.
module jtag_tap_target
    import jtag_tap_target_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tms,
    input  logic                       tdi,
    output logic                       tdo,
    output logic                       tdoEn,
    output logic [TAP_STATE_WIDTH-1:0] tapState,
    output logic [INSTR_WIDTH-1:0]     instrReg,
    output logic                       instrValid,
    input  logic [DATA_WIDTH-1:0]      dataIn,
    output logic [DATA_WIDTH-1:0]      dataOut,
    output logic                       dataValid
);

`ifdef JTAG_TAP_IDCODE_EN
    localparam logic        IDCODE_EN    = 1'b1;
    localparam int unsigned IDCODE_WIDTH = 32;
    logic [IDCODE_WIDTH-1:0] idcode_shift;
`else
    localparam logic IDCODE_EN = 1'b0;
    logic unused_idcode;
    assign unused_idcode = ^IDCODE_VALUE;
`endif

    logic [TAP_STATE_WIDTH-1:0] tap_state;
    logic [TAP_STATE_WIDTH-1:0] tap_next_c;
    logic [INSTR_WIDTH-1:0]     ir_shift;
    logic [DATA_WIDTH-1:0]      tvr_shift;
    logic                       bypass_reg;
    dr_sel_e                    dr_sel;

    jtag_tap_fsm u_fsm (
        .clk          (clk),
        .reset        (reset),
        .tms          (tms),
        .tap_state    (tap_state),
        .next_state_c (tap_next_c)
    );

    assign tapState = tap_state;
    assign dr_sel   = decode_instr(OPCODE_WIDTH'(instrReg), IDCODE_EN);

    // IR shift register: capture pattern 0..01, then shift right from tdi
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_shift <= '0;
        end else begin
            case (tap_state)
                ST_CAPTURE_IR: ir_shift <= INSTR_WIDTH'(2'b01);
                ST_SHIFT_IR:   ir_shift <= {tdi, ir_shift[INSTR_WIDTH-1:1]};
                default:       ir_shift <= ir_shift;
            endcase
        end
    end

    // Active instruction: cleared on the way into Test-Logic-Reset, loaded at Update-IR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instrReg   <= INSTR_WIDTH'(OP_BYPASS);
            instrValid <= 1'b0;
        end else begin
            instrValid <= 1'b0;
            if (tap_next_c == ST_TEST_LOGIC_RESET) begin
                instrReg <= INSTR_WIDTH'(OP_BYPASS);
            end else if (tap_state == ST_UPDATE_IR) begin
                instrReg   <= ir_shift;
                instrValid <= 1'b1;
            end
        end
    end

    // TVR capture/shift, only touched while it is the selected data register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tvr_shift <= '0;
        end else if (dr_sel == DR_SEL_TVR) begin
            if (tap_state == ST_CAPTURE_DR) begin
                tvr_shift <= dataIn;
            end else if (tap_state == ST_SHIFT_DR) begin
                tvr_shift <= {tdi, tvr_shift[DATA_WIDTH-1:1]};
            end
        end
    end

    // Bypass bit: captures 0, then gives a one-clock tdi-to-tdo delay
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bypass_reg <= 1'b0;
        end else if (dr_sel == DR_SEL_BYPASS) begin
            if (tap_state == ST_CAPTURE_DR) begin
                bypass_reg <= 1'b0;
            end else if (tap_state == ST_SHIFT_DR) begin
                bypass_reg <= tdi;
            end
        end
    end

`ifdef JTAG_TAP_IDCODE_EN
    // IDCODE capture/shift; read-only so nothing is committed at Update-DR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idcode_shift <= '0;
        end else if (dr_sel == DR_SEL_IDCODE) begin
            if (tap_state == ST_CAPTURE_DR) begin
                idcode_shift <= IDCODE_VALUE;
            end else if (tap_state == ST_SHIFT_DR) begin
                idcode_shift <= {tdi, idcode_shift[IDCODE_WIDTH-1:1]};
            end
        end
    end
`endif

    // Commit the shifted test vector to the DUT side at Update-DR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataOut   <= '0;
            dataValid <= 1'b0;
        end else begin
            dataValid <= 1'b0;
            if ((tap_state == ST_UPDATE_DR) && (dr_sel == DR_SEL_TVR)) begin
                dataOut   <= tvr_shift;
                dataValid <= 1'b1;
            end
        end
    end

    // tdo mux: LSB of the active shift register, quiet outside shift states
    always_comb begin
        tdo   = 1'b0;
        tdoEn = 1'b0;
        case (tap_state)
            ST_SHIFT_IR: begin
                tdoEn = 1'b1;
                tdo   = ir_shift[0];
            end
            ST_SHIFT_DR: begin
                tdoEn = 1'b1;
                case (dr_sel)
                    DR_SEL_TVR:    tdo = tvr_shift[0];
`ifdef JTAG_TAP_IDCODE_EN
                    DR_SEL_IDCODE: tdo = idcode_shift[0];
`endif
                    default:       tdo = bypass_reg;
                endcase
            end
            default: begin
                tdo   = 1'b0;
                tdoEn = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_jtag_tap_target.sv
// Directed bench for jtag_tap_target: a queue model of the active shift
// register supplies each expected tdo bit and the committed register value.
module tb_jtag_tap_target;

    localparam int unsigned IW = 5;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset;
    logic          tms;
    logic          tdi;
    logic          tdo;
    logic          tdoEn;
    logic [3:0]    tapState;
    logic [IW-1:0] instrReg;
    logic          instrValid;
    logic [DW-1:0] dataIn;
    logic [DW-1:0] dataOut;
    logic          dataValid;

    int checks   = 0;
    int failures = 0;

    logic        model_q[$];
    logic [31:0] exp_data_out;

    jtag_tap_target #(
        .INSTR_WIDTH  (IW),
        .DATA_WIDTH   (DW),
        .IDCODE_VALUE (32'h1000_0001)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tms        (tms),
        .tdi        (tdi),
        .tdo        (tdo),
        .tdoEn      (tdoEn),
        .tapState   (tapState),
        .instrReg   (instrReg),
        .instrValid (instrValid),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
        .dataValid  (dataValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One TCK: drive at negedge, sample tdo before the rising edge, settle after it
    task automatic tick(input logic tms_v, input logic tdi_v, output logic tdo_s);
        @(negedge clk);
        tms = tms_v;
        tdi = tdi_v;
        #1;
        tdo_s = tdo;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic tms_v);
        logic dummy;
        tick(tms_v, 1'b0, dummy);
    endtask

    task automatic load_model(input logic [31:0] v, input int w);
        model_q.delete();
        for (int i = 0; i < w; i++) model_q.push_back(v[i]);
    endtask

    function automatic logic [31:0] model_value();
        logic [31:0] v;
        v = '0;
        foreach (model_q[i]) v[i] = model_q[i];
        return v;
    endfunction

    // Expected tdo is popped from the model as the matching tdi bit is pushed
    task automatic shift_bits(input string tag, input logic [31:0] bits, input int n,
                              input logic exit_last);
        logic exp_bit;
        logic obs;
        for (int i = 0; i < n; i++) begin
            exp_bit = model_q.pop_front();
            model_q.push_back(bits[i]);
            tick(exit_last && (i == n - 1), bits[i], obs);
            check(tag, 32'(obs), 32'(exp_bit));
        end
    endtask

    // From Run-Test/Idle: shift n IR bits, update, back to idle
    task automatic load_ir(input logic [31:0] bits, input int n);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        load_model(32'h1, IW);
        shift_bits("ir_tdo", bits, n, 1'b1);
        step(1'b1);
        step(1'b0);
        check("instr_reg", 32'(instrReg), model_value());
        check("instr_valid_hi", 32'(instrValid), 32'h1);
        step(1'b0);
        check("instr_valid_lo", 32'(instrValid), 32'h0);
    endtask

    task automatic enter_shift_dr();
        step(1'b1);
        step(1'b0);
        step(1'b0);
    endtask

    task automatic update_dr();
        step(1'b1);
        step(1'b0);
    endtask

    initial begin
        reset  = 1'b0;
        tms    = 1'b1;
        tdi    = 1'b0;
        dataIn = 32'hDEAD_BEEF;
        exp_data_out = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_state", 32'(tapState), 32'hF);
        check("rst_instr", 32'(instrReg), 32'h0);
        check("rst_tdo", 32'(tdo), 32'h0);
        check("rst_tdoen", 32'(tdoEn), 32'h0);
        check("rst_ivalid", 32'(instrValid), 32'h0);
        check("rst_dvalid", 32'(dataValid), 32'h0);
        check("rst_dout", 32'(dataOut), 32'h0);

        step(1'b0);
        check("rti_state", 32'(tapState), 32'hC);

        // Load TVR opcode; capture pattern must come out as 1,0,0,0,0
        load_ir(32'h1, IW);
        check("instr_tvr", 32'(instrReg), 32'h1);

        // Five tms=1 from idle reaches Test-Logic-Reset and clears the instruction
        repeat (5) step(1'b1);
        check("tlr_state", 32'(tapState), 32'hF);
        check("tlr_instr", 32'(instrReg), 32'h0);
        check("tlr_tdo", 32'(tdo), 32'h0);
        check("tlr_tdoen", 32'(tdoEn), 32'h0);

        // Reset in the middle of a TVR shift
        step(1'b0);
        load_ir(32'h1, IW);
        dataIn = 32'hDEAD_BEEF;
        enter_shift_dr();
        load_model(32'hDEAD_BEEF, DW);
        shift_bits("mid_tdo", 32'hA5A5_1234, 10, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_state", 32'(tapState), 32'hF);
        check("mid_rst_instr", 32'(instrReg), 32'h0);
        check("mid_rst_tdo", 32'(tdo), 32'h0);
        check("mid_rst_tdoen", 32'(tdoEn), 32'h0);
        check("mid_rst_dout", 32'(dataOut), exp_data_out);
        check("mid_rst_dvalid", 32'(dataValid), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0);

        // Full TVR round trip
        load_ir(32'h1, IW);
        dataIn = 32'hDEAD_BEEF;
        enter_shift_dr();
        load_model(32'hDEAD_BEEF, DW);
        shift_bits("tvr_tdo", 32'hA5A5_1234, 32, 1'b1);
        update_dr();
        exp_data_out = 32'hA5A5_1234;
        check("tvr_dout", 32'(dataOut), exp_data_out);
        check("tvr_dvalid_hi", 32'(dataValid), 32'h1);
        step(1'b0);
        check("tvr_dvalid_lo", 32'(dataValid), 32'h0);

        // Bypass: one-clock delay, nothing committed
        load_ir(32'h0, IW);
        enter_shift_dr();
        check("byp_tdoen", 32'(tdoEn), 32'h1);
        load_model(32'h0, 1);
        shift_bits("byp_tdo", 32'h0000_000D, 4, 1'b1);
        update_dr();
        check("byp_dout", 32'(dataOut), exp_data_out);
        check("byp_dvalid", 32'(dataValid), 32'h0);
        step(1'b0);
        check("byp_dvalid2", 32'(dataValid), 32'h0);

        // Short TVR shift commits the partially shifted register
        load_ir(32'h1, IW);
        dataIn = 32'h1234_5678;
        enter_shift_dr();
        load_model(32'h1234_5678, DW);
        shift_bits("short_tdo", 32'h0000_00C3, 8, 1'b1);
        update_dr();
        exp_data_out = 32'hC312_3456;
        check("short_model", model_value(), exp_data_out);
        check("short_dout", 32'(dataOut), exp_data_out);
        check("short_dvalid", 32'(dataValid), 32'h1);

        // Long IR shift: leading bits fall off, last five bits form the opcode
        load_ir(32'h0000_0004, 7);
        check("long_ir_instr", 32'(instrReg), 32'h1);

        // Opcode 2: IDCODE when enabled, otherwise bypass
        load_ir(32'h2, IW);
        enter_shift_dr();
`ifdef JTAG_TAP_IDCODE_EN
        load_model(32'h1000_0001, 32);
`else
        load_model(32'h0, 1);
`endif
        shift_bits("op2_tdo", 32'h0F0F_00FF, 32, 1'b1);
        update_dr();
        check("op2_dout", 32'(dataOut), exp_data_out);
        check("op2_dvalid", 32'(dataValid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
